// File: rtl/pisa_mem_pkg.sv
// Shared constants and state type for the pixel-RAM access blocks.
//   ADDR_W        RAM word-address width
//   DATA_W        RAM word width
//   PIX_W         pixel width
//   PIX_PER_WORD  pixels packed into one RAM word
//   rd_state_t    reader FSM states
package pisa_mem_pkg;

  localparam int unsigned ADDR_W       = 19;
  localparam int unsigned DATA_W       = 32;
  localparam int unsigned PIX_W        = 8;
  localparam int unsigned PIX_PER_WORD = DATA_W / PIX_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } rd_state_t;

endpackage

// File: rtl/pix_word_fifo.sv
// Synchronous word FIFO between the RAM read return and the pixel unpacker.
//   clock, reset  rising-edge clock, synchronous active-high reset
//   push/push_data  write a word (accepted when not full, or when popping too)
//   pop/pop_data    read the head word; pop_data is the current head
//   full, empty     occupancy flags
//   count           number of stored words (0..DEPTH)
module pix_word_fifo #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic [DATA_W-1:0]        pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/ram_pixel_reader.sv
// Read master for one port of the pixel RAM. On start, fetches word_count
// consecutive words from base_addr and streams them out as pixels, lane 0
// first, with valid/ready handshaking. The RAM write controls are held idle.
//   clock, reset           rising-edge clock, synchronous active-high reset
//   start                  request, sampled only while idle
//   base_addr, word_count  transfer descriptor, captured on start
//   busy, done             transfer active / one-cycle completion pulse
//   address, byteena, data, wren   RAM port controls (read only)
//   q                      RAM read data, RD_LAT clocks after address
//   pix_data, pix_valid, pix_ready, pix_last   pixel stream
module ram_pixel_reader
  import pisa_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = pisa_mem_pkg::ADDR_W,
  parameter int unsigned DATA_W = pisa_mem_pkg::DATA_W,
  parameter int unsigned PIX_W  = pisa_mem_pkg::PIX_W,
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned FIFO_D = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] word_count,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] address,
  output logic [3:0]        byteena,
  output logic [DATA_W-1:0] data,
  output logic              wren,
  input  logic [DATA_W-1:0] q,
  output logic [PIX_W-1:0]  pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_last
);

  localparam int unsigned PPW   = DATA_W / PIX_W;
  localparam int unsigned IDX_W = (PPW > 1) ? $clog2(PPW) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_D) + 1;

  rd_state_t         state;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] issue_left;
  logic [ADDR_W-1:0] pop_left;
  logic [ADDR_W-1:0] addr_hold;

  logic [RD_LAT-1:0] rd_pipe;
  logic [RD_LAT-1:0] rd_pipe_n;
  logic [CNT_W-1:0]  in_flight;

  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_pop;
  logic [CNT_W-1:0]  fifo_count;
  logic [DATA_W-1:0] fifo_rd;

  logic              load;
  logic              credit;
  logic              issue;
  logic              ret;
  logic              accept;
  logic              last_byte;
  logic              last_pix;
  logic              drain_done;

  logic [DATA_W-1:0] word_q;
  logic [IDX_W-1:0]  byte_idx;
  logic              word_last;
  logic              valid_q;

  // ---------------------------------------------------------------
  // Issue side
  // ---------------------------------------------------------------
  assign load   = (state == IDLE) && start;
  // Words already buffered plus reads still in the RAM pipe must fit.
  assign credit = !fifo_full &&
                  (({1'b0, fifo_count} + {1'b0, in_flight}) < (CNT_W + 1)'(FIFO_D));
  assign issue  = (state == FETCH) && credit;
  assign ret    = rd_pipe[RD_LAT-1];

  // Address is driven straight from rd_ptr in the issue cycle so the RAM
  // sees it without an extra register stage; otherwise it holds.
  assign address = issue ? rd_ptr : addr_hold;

  assign busy    = (state == FETCH) || (state == DRAIN);
  assign done    = (state == DONE);
  assign byteena = '1;
  assign data    = '0;
  assign wren    = 1'b0;

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      rd_ptr     <= '0;
      issue_left <= '0;
      addr_hold  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            rd_ptr     <= base_addr;
            issue_left <= word_count;
            state      <= (word_count == '0) ? DONE : FETCH;
          end
        end
        FETCH: begin
          if (issue) begin
            addr_hold  <= rd_ptr;
            rd_ptr     <= rd_ptr + ADDR_W'(1);
            issue_left <= issue_left - ADDR_W'(1);
            if (issue_left == ADDR_W'(1)) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (drain_done) begin
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------
  // Read-return tracking
  // ---------------------------------------------------------------
  always_comb begin
    rd_pipe_n    = '0;
    rd_pipe_n[0] = issue;
    for (int unsigned i = 1; i < RD_LAT; i++) begin
      rd_pipe_n[i] = rd_pipe[i-1];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_pipe   <= '0;
      in_flight <= '0;
    end else begin
      rd_pipe   <= rd_pipe_n;
      in_flight <= in_flight + CNT_W'(issue) - CNT_W'(ret);
    end
  end

  pix_word_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_D)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (ret),
    .push_data (q),
    .pop       (fifo_pop),
    .pop_data  (fifo_rd),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // ---------------------------------------------------------------
  // Unpacker
  // ---------------------------------------------------------------
  assign accept     = valid_q && pix_ready;
  assign last_byte  = (byte_idx == IDX_W'(PPW - 1));
  // Refill on the same edge the final lane is taken so words stream
  // back to back without a bubble.
  assign fifo_pop   = !fifo_empty && (!valid_q || (accept && last_byte));
  assign last_pix   = valid_q && word_last && last_byte;
  assign drain_done = (in_flight == '0) && fifo_empty && accept && last_pix;

  assign pix_valid = valid_q;
  assign pix_last  = last_pix;
  // The word register shifts down one lane per accepted pixel.
  assign pix_data  = word_q[PIX_W-1:0];

  always_ff @(posedge clock) begin
    if (reset) begin
      word_q    <= '0;
      byte_idx  <= '0;
      word_last <= 1'b0;
      valid_q   <= 1'b0;
      pop_left  <= '0;
    end else begin
      if (load) begin
        pop_left <= word_count;
      end
      if (fifo_pop) begin
        word_q    <= fifo_rd;
        byte_idx  <= '0;
        valid_q   <= 1'b1;
        word_last <= (pop_left == ADDR_W'(1));
        pop_left  <= pop_left - ADDR_W'(1);
      end else if (accept) begin
        if (last_byte) begin
          valid_q <= 1'b0;
        end else begin
          word_q   <= word_q >> PIX_W;
          byte_idx <= byte_idx + IDX_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_ram_pixel_reader.sv
module tb_ram_pixel_reader;

  typedef logic [0:11][7:0] pxv_t;

  typedef struct {
    logic [18:0] base;
    logic [18:0] cnt;
    int unsigned mode;   // 0: ready=1, 1: ready 1010.., 2: ready 1100..
    bit          poke;   // pulse start again mid-transfer
    int unsigned n;
    pxv_t        px;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [18:0] base_addr;
  logic [18:0] word_count;
  logic        busy;
  logic        done;
  logic [18:0] address;
  logic [3:0]  byteena;
  logic [31:0] data;
  logic        wren;
  logic [31:0] q;
  logic [7:0]  pix_data;
  logic        pix_valid;
  logic        pix_ready;
  logic        pix_last;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [bit [18:0]];

  always #5 clock = ~clock;

  // RAM port B model, one clock read latency.
  always @(posedge clock) begin
    q <= mem.exists(address) ? mem[address] : 32'h0;
  end

  ram_pixel_reader #(
    .ADDR_W (19),
    .DATA_W (32),
    .PIX_W  (8),
    .RD_LAT (1),
    .FIFO_D (4)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .busy       (busy),
    .done       (done),
    .address    (address),
    .byteena    (byteena),
    .data       (data),
    .wren       (wren),
    .q          (q),
    .pix_data   (pix_data),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_last   (pix_last)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " busy"}, 32'(busy), 32'h0);
    chk({tag, " done"}, 32'(done), 32'h0);
    chk({tag, " address"}, 32'(address), 32'h0);
    chk({tag, " pix_valid"}, 32'(pix_valid), 32'h0);
    chk({tag, " pix_last"}, 32'(pix_last), 32'h0);
    chk({tag, " pix_data"}, 32'(pix_data), 32'h0);
  endtask

  task automatic chk_port_ctrl();
    chk("wren", 32'(wren), 32'h0);
    chk("byteena", 32'(byteena), 32'hF);
    chk("wdata", data, 32'h0);
  endtask

  task automatic run_xfer(input logic [18:0] b, input logic [18:0] c, input int unsigned mode,
                          input bit poke, input int unsigned n, input pxv_t px);
    int unsigned got = 0;
    int first_k = -1;
    int last_k = -1;
    int done_k = -1;
    int prev_k = -1;
    bit stall = 1'b0;
    logic [7:0] st_d = '0;
    logic st_l = 1'b0;

    @(posedge clock); #1;
    base_addr  = b;
    word_count = c;
    start      = 1'b1;
    pix_ready  = 1'b1;
    for (int k = 1; k <= 200 && done_k < 0; k++) begin
      @(posedge clock); #1;
      start = 1'b0;
      if (poke && k == 5) begin
        start      = 1'b1;
        base_addr  = 19'h3;
        word_count = 19'h1;
      end
      case (mode)
        1:       pix_ready = (k % 2 == 0);
        2:       pix_ready = ((k / 2) % 2 == 0);
        default: pix_ready = 1'b1;
      endcase
      @(negedge clock);
      chk_port_ctrl();
      if (k == 1) chk("busy after start", 32'(busy), 32'h1);
      if (stall) begin
        chk("stall valid", 32'(pix_valid), 32'h1);
        chk("stall data", 32'(pix_data), 32'(st_d));
        chk("stall last", 32'(pix_last), 32'(st_l));
      end
      if (pix_valid && first_k < 0) first_k = k;
      if (done) done_k = k;
      if (pix_valid && pix_ready) begin
        if (got < n) begin
          chk($sformatf("pixel %0d", got), 32'(pix_data), 32'(px[got]));
          chk($sformatf("last %0d", got), 32'(pix_last), 32'(got == n - 1));
        end else begin
          chk("extra pixel", 32'(got), 32'(n - 1));
        end
        if (mode == 0 && prev_k >= 0) chk("no bubble", 32'(k), 32'(prev_k + 1));
        prev_k = k;
        last_k = k;
        got++;
      end
      stall = pix_valid && !pix_ready;
      st_d  = pix_data;
      st_l  = pix_last;
    end
    if (done_k < 0) begin
      checks++;
      errors++;
      $display("FAIL done timeout: got none expected pulse within 200 cycles");
    end
    chk("pixel count", 32'(got), 32'(n));
    chk("first pixel latency", 32'(first_k - 1), 32'h3);
    chk("done after last", 32'(done_k), 32'(last_k + 1));
    for (int k = 0; k < 3; k++) begin
      @(posedge clock); #1;
      @(negedge clock);
      chk("idle done", 32'(done), 32'h0);
      chk("idle busy", 32'(busy), 32'h0);
      chk("idle valid", 32'(pix_valid), 32'h0);
    end
  endtask

  vec_t vecs [5];

  initial begin
    vecs[0] = '{base: 19'h1, cnt: 19'h2, mode: 0, poke: 1'b0, n: 8,
                px: {8'hBE, 8'hBA, 8'hFE, 8'hCA, 8'h78, 8'h56, 8'h34, 8'h12, 32'h0}};
    vecs[1] = '{base: 19'h1, cnt: 19'h2, mode: 1, poke: 1'b0, n: 8,
                px: {8'hBE, 8'hBA, 8'hFE, 8'hCA, 8'h78, 8'h56, 8'h34, 8'h12, 32'h0}};
    vecs[2] = '{base: 19'h7FFFF, cnt: 19'h2, mode: 0, poke: 1'b0, n: 8,
                px: {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 32'h0}};
    vecs[3] = '{base: 19'h3, cnt: 19'h3, mode: 2, poke: 1'b0, n: 12,
                px: {8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
                     8'h08, 8'h09, 8'h0A, 8'h0B}};
    vecs[4] = '{base: 19'h1, cnt: 19'h2, mode: 0, poke: 1'b1, n: 8,
                px: {8'hBE, 8'hBA, 8'hFE, 8'hCA, 8'h78, 8'h56, 8'h34, 8'h12, 32'h0}};

    mem[19'h00001] = 32'hCAFEBABE;
    mem[19'h00002] = 32'h12345678;
    mem[19'h00003] = 32'h03020100;
    mem[19'h00004] = 32'h07060504;
    mem[19'h00005] = 32'h0B0A0908;
    mem[19'h7FFFF] = 32'h44332211;
    mem[19'h00000] = 32'h88776655;

    reset      = 1'b1;
    start      = 1'b0;
    base_addr  = '0;
    word_count = '0;
    pix_ready  = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    chk_reset_vals("reset");
    chk_port_ctrl();

    for (int i = 0; i < 5; i++) begin
      run_xfer(vecs[i].base, vecs[i].cnt, vecs[i].mode, vecs[i].poke, vecs[i].n, vecs[i].px);
    end

    // Zero-length transfer: done pulses, no fetch, no pixels.
    begin
      logic [18:0] addr_prev;
      int done_cnt = 0;
      int done_k = -1;
      @(posedge clock); #1;
      addr_prev  = address;
      base_addr  = 19'h5;
      word_count = 19'h0;
      start      = 1'b1;
      for (int k = 1; k <= 6; k++) begin
        @(posedge clock); #1;
        start = 1'b0;
        @(negedge clock);
        chk("zero busy", 32'(busy), 32'h0);
        chk("zero valid", 32'(pix_valid), 32'h0);
        chk("zero address", 32'(address), 32'(addr_prev));
        if (done) begin
          done_cnt++;
          if (done_k < 0) done_k = k;
        end
      end
      chk("zero done count", 32'(done_cnt), 32'h1);
      chk("zero done cycle", 32'(done_k), 32'h1);
    end

    // Reset after three pixels, then a fresh transfer.
    begin
      int acc = 0;
      @(posedge clock); #1;
      base_addr  = 19'h1;
      word_count = 19'h2;
      start      = 1'b1;
      pix_ready  = 1'b1;
      for (int k = 1; k <= 50 && acc < 3; k++) begin
        @(posedge clock); #1;
        start = 1'b0;
        @(negedge clock);
        if (pix_valid && pix_ready) acc++;
      end
      chk("pixels before reset", 32'(acc), 32'h3);
      @(posedge clock); #1;
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      @(negedge clock);
      chk_reset_vals("mid reset");
      for (int k = 0; k < 6; k++) begin
        @(posedge clock);
        @(negedge clock);
        chk("post reset valid", 32'(pix_valid), 32'h0);
        chk("post reset busy", 32'(busy), 32'h0);
      end
      run_xfer(19'h2, 19'h1, 0, 1'b0, 4, {8'h78, 8'h56, 8'h34, 8'h12, 64'h0});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
